// File: rtl/qpp_deinterleaver.sv
// QPP de-interleaver: collects a bit-serial block in c_pi order into a 6144x1
// buffer at address pi(i) = (f1*i + f2*i^2) mod K, then streams it out as
// natural-order bytes (LSB = lowest bit index) under a valid/ready handshake.
// pi(i) is tracked incrementally: pi += g, g += 2*f2, both mod K.
module qpp_deinterleaver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       k_size_6144_i,
  input  logic       start_i,
  input  logic       bit_in_i,
  input  logic       bit_valid_i,
  input  logic       byte_ready_i,
  output logic [7:0] byte_out_o,
  output logic       byte_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned K_MAX     = 6144;
  localparam int unsigned IDX_W     = 13;   // bit index 0..6143
  localparam int unsigned MOD_W     = 14;   // pi / g registers
  localparam int unsigned SUM_W     = 15;   // un-reduced sum
  localparam int unsigned BYTE_W    = 10;   // byte index 0..767

  localparam int unsigned K_SMALL   = 1056;
  localparam int unsigned K_LARGE   = 6144;
  localparam int unsigned F1_SMALL  = 17;
  localparam int unsigned F2_SMALL  = 66;
  localparam int unsigned F1_LARGE  = 263;
  localparam int unsigned F2_LARGE  = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q;
  logic               k_large_q;
  logic [IDX_W-1:0]   i_q;
  logic [MOD_W-1:0]   pi_q;
  logic [MOD_W-1:0]   g_q;
  logic [BYTE_W-1:0]  j_q;
  logic [7:0]         byte_out_q;
  logic               byte_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [K_MAX-1:0]   buf_q;

  logic [SUM_W-1:0]   k_cur;
  logic [MOD_W-1:0]   two_f2;
  logic [IDX_W-1:0]   i_last;
  logic [BYTE_W-1:0]  j_last;
  logic [SUM_W-1:0]   pi_sum;
  logic [SUM_W-1:0]   g_sum;
  logic [MOD_W-1:0]   pi_d;
  logic [MOD_W-1:0]   g_d;
  logic               bit_acc;
  logic [BYTE_W-1:0]  j_load;
  logic [7:0]         load_byte_d;

  // Per-block constants selected by the latched block size
  always_comb begin
    k_cur  = k_large_q ? SUM_W'(K_LARGE)       : SUM_W'(K_SMALL);
    two_f2 = k_large_q ? MOD_W'(2 * F2_LARGE)  : MOD_W'(2 * F2_SMALL);
    i_last = k_large_q ? IDX_W'(K_LARGE - 1)   : IDX_W'(K_SMALL - 1);
    j_last = k_large_q ? BYTE_W'(K_LARGE / 8 - 1) : BYTE_W'(K_SMALL / 8 - 1);
  end

  // Address recurrence with a single conditional subtract (operands < K)
  always_comb begin
    pi_sum = SUM_W'(pi_q) + SUM_W'(g_q);
    g_sum  = SUM_W'(g_q) + SUM_W'(two_f2);
    pi_d   = (pi_sum >= k_cur) ? MOD_W'(pi_sum - k_cur) : MOD_W'(pi_sum);
    g_d    = (g_sum  >= k_cur) ? MOD_W'(g_sum  - k_cur) : MOD_W'(g_sum);
  end

  // Next byte to present; forwards the bit being written on the FILL->DRAIN edge
  always_comb begin
    bit_acc     = (state_q == FILL) && bit_valid_i;
    j_load      = (state_q == FILL) ? '0 : BYTE_W'(j_q + BYTE_W'(1));
    load_byte_d = buf_q[{j_load, 3'b000} +: 8];
    if (bit_acc && (pi_q[IDX_W-1:3] == j_load)) begin
      load_byte_d[pi_q[2:0]] = bit_in_i;
    end
  end

  // Bit buffer: written only while filling, never reset
  always_ff @(posedge clk) begin
    if (bit_acc) begin
      buf_q[pi_q[IDX_W-1:0]] <= bit_in_i;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_large_q    <= 1'b0;
      i_q          <= '0;
      pi_q         <= '0;
      g_q          <= '0;
      j_q          <= '0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            k_large_q <= k_size_6144_i;
            i_q       <= '0;
            pi_q      <= '0;
            g_q       <= k_size_6144_i ? MOD_W'(F1_LARGE + F2_LARGE)
                                       : MOD_W'(F1_SMALL + F2_SMALL);
            busy_q    <= 1'b1;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (bit_valid_i) begin
            i_q  <= IDX_W'(i_q + IDX_W'(1));
            pi_q <= pi_d;
            g_q  <= g_d;
            if (i_q == i_last) begin
              j_q          <= '0;
              byte_out_q   <= load_byte_d;
              byte_valid_q <= 1'b1;
              state_q      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (byte_ready_i) begin
            if (j_q == j_last) begin
              byte_valid_q <= 1'b0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              j_q        <= j_load;
              byte_out_q <= load_byte_d;
            end
          end
        end
        default: begin
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign byte_out_o   = byte_out_q;
  assign byte_valid_o = byte_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Directed bench for qpp_deinterleaver: single-one vectors from a table plus
// round-trip, backpressure, reset-abort and ignored-input sequences.
module tb_qpp_deinterleaver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k_size_6144_i;
  logic       start_i;
  logic       bit_in_i;
  logic       bit_valid_i;
  logic       byte_ready_i;
  logic [7:0] byte_out_o;
  logic       byte_valid_o;
  logic       busy_o;
  logic       done_o;

  qpp_deinterleaver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .k_size_6144_i(k_size_6144_i),
    .start_i      (start_i),
    .bit_in_i     (bit_in_i),
    .bit_valid_i  (bit_valid_i),
    .byte_ready_i (byte_ready_i),
    .byte_out_o   (byte_out_o),
    .byte_valid_o (byte_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         k6144;
    int         one_idx;   // stream position carrying the single 1
    int         exp_byte;  // byte where it must land
    logic [7:0] exp_val;
  } vec_t;

  vec_t       vecs[7];
  logic       stream[6144];
  logic       c_bits[6144];
  logic [7:0] exp_bytes[768];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pi_of(input int k, input int i);
    longint f1, f2, li;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    li = i;
    return int'((f1 * li + f2 * li * li) % longint'(k));
  endfunction

  // Random natural-order block, interleaved stream and expected bytes
  task automatic prep_roundtrip(input int k);
    for (int n = 0; n < k; n++) c_bits[n] = 1'($urandom_range(1));
    for (int i = 0; i < k; i++) stream[i] = c_bits[pi_of(k, i)];
    for (int j = 0; j < k / 8; j++)
      for (int b = 0; b < 8; b++) exp_bytes[j][b] = c_bits[8 * j + b];
  endtask

  // Run one block from start to done and compare every byte
  task automatic run_block(input bit k6144, input int gap_pct, input bit stall0,
                           input bit start_in_drain);
    int k, nb, got, budget, stall_cnt;
    k = k6144 ? 6144 : 1056;
    nb = k / 8;
    start_i = 1'b1;
    k_size_6144_i = k6144;
    tick();
    start_i = 1'b0;
    k_size_6144_i = ~k6144;
    check("busy_after_start", 32'(busy_o), 32'd1);
    for (int i = 0; i < k; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bit_valid_i = 1'b0;
        bit_in_i = 1'($urandom_range(1));
        tick();
      end
      bit_valid_i = 1'b1;
      bit_in_i = stream[i];
      tick();
    end
    bit_valid_i = 1'b0;
    check("first_byte_latency", 32'(byte_valid_o), 32'd1);
    got = 0;
    budget = 0;
    stall_cnt = 0;
    while (got < nb && budget < 4 * nb + 20) begin
      if (stall0 && got == 0 && stall_cnt < 5) begin
        byte_ready_i = 1'b0;
        check("stall_valid", 32'(byte_valid_o), 32'd1);
        check("stall_data", 32'(byte_out_o), 32'(exp_bytes[0]));
        stall_cnt++;
      end else begin
        byte_ready_i = 1'b1;
      end
      start_i = start_in_drain;
      if (byte_valid_o && byte_ready_i) begin
        if (byte_out_o !== exp_bytes[got]) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte[%0d]: got %02h, expected %02h", got, byte_out_o, exp_bytes[got]);
        end else begin
          n_checks++;
        end
        got++;
      end
      tick();
      budget++;
    end
    start_i = 1'b0;
    byte_ready_i = 1'b0;
    check("byte_count", 32'(got), 32'(nb));
    check("done_pulse", 32'(done_o), 32'd1);
    check("busy_at_done", 32'(busy_o), 32'd0);
    check("valid_at_done", 32'(byte_valid_o), 32'd0);
    tick();
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("busy_after_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1,    10,  8'h08};
    vecs[1] = '{1'b1, 2,    305, 8'h40};
    vecs[2] = '{1'b0, 0,    0,   8'h01};
    vecs[3] = '{1'b0, 3,    80,  8'h20};
    vecs[4] = '{1'b0, 1055, 6,   8'h02};
    vecs[5] = '{1'b1, 6143, 27,  8'h02};
    vecs[6] = '{1'b1, 1,    92,  8'h80};

    rst_n = 1'b0;
    k_size_6144_i = 1'b0;
    start_i = 1'b0;
    bit_in_i = 1'b0;
    bit_valid_i = 1'b0;
    byte_ready_i = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(byte_valid_o), 32'd0);
    check("rst_byte", 32'(byte_out_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-one vectors
    for (int t = 0; t < 7; t++) begin
      int k;
      k = vecs[t].k6144 ? 6144 : 1056;
      for (int i = 0; i < 6144; i++) stream[i] = 1'b0;
      stream[vecs[t].one_idx] = 1'b1;
      for (int j = 0; j < 768; j++) exp_bytes[j] = 8'h00;
      exp_bytes[vecs[t].exp_byte] = vecs[t].exp_val;
      run_block(vecs[t].k6144, (t == 3) ? 20 : 0, 1'b0, 1'b0);
      if (k == 0) $display("unreachable");
    end

    // Round trip with random gaps
    prep_roundtrip(6144);
    run_block(1'b1, 25, 1'b0, 1'b0);

    // Backpressure on byte 0
    prep_roundtrip(1056);
    run_block(1'b0, 10, 1'b1, 1'b0);

    // Reset mid-FILL at i=500
    prep_roundtrip(1056);
    start_i = 1'b1;
    k_size_6144_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bit_valid_i = 1'b1;
      bit_in_i = stream[i];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_valid", 32'(byte_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 1100; n++) tick();
    check("post_abort_valid", 32'(byte_valid_o), 32'd0);
    check("post_abort_busy", 32'(busy_o), 32'd0);
    bit_valid_i = 1'b0;
    prep_roundtrip(1056);
    run_block(1'b0, 0, 1'b0, 1'b0);

    // bit_valid in IDLE, then start held through DRAIN
    bit_valid_i = 1'b1;
    bit_in_i = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    bit_valid_i = 1'b0;
    check("idle_bits_busy", 32'(busy_o), 32'd0);
    check("idle_bits_valid", 32'(byte_valid_o), 32'd0);
    prep_roundtrip(1056);
    run_block(1'b0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpp_deinterleaver.md
QPP_DEINTERLEAVER -- requirements
Module: qpp_deinterleaver

Interface
REQ-001 Parameters: none; block sizes K=1056 and K=6144 are fixed in RTL.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 k_size_6144  input  1  0 = K 1056, 1 = K 6144; sampled only when start is accepted.
REQ-005 start  input  1  one-cycle request to begin receiving a block.
REQ-006 bit_in  input  1  bit-serial permuted stream (c_pi order).
REQ-007 bit_valid  input  1  qualifies bit_in.
REQ-008 byte_out  output  8  de-interleaved byte, natural order.
REQ-009 byte_valid  output  1  byte_out holds a valid byte.
REQ-010 byte_ready  input  1  downstream accepts byte_out when byte_valid and byte_ready are both high.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse after the last byte of a block is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, FILL, DRAIN.
REQ-014 IDLE: start=1 SHALL latch the K select and clear i=0, pi=0, g=(f1+f2) mod K, then go to FILL. Coefficients: K=1056 uses f1=17, f2=66; K=6144 uses f1=263, f2=480.
REQ-015 FILL: each cycle with bit_valid=1 SHALL write buf[pi] <= bit_in, then update i <= i+1, pi <= (pi+g) mod K, g <= (g+2*f2) mod K.
REQ-016 Modular reduction SHALL be a single conditional subtract of K; operands are always < K. Use 14-bit pi/g and a 15-bit sum; no multipliers.
REQ-017 Cycles with bit_valid=0 in FILL SHALL leave all counters and buf unchanged; gaps are unlimited.
REQ-018 Acceptance of bit i=K-1 SHALL move the FSM to DRAIN on the next edge.
REQ-019 DRAIN: byte j (j=0..K/8-1, i.e. 132 or 768 bytes) SHALL present byte_out[b] = buf[8j+b] for b=0..7.
REQ-020 byte_valid SHALL rise in the first cycle of DRAIN; first-byte latency is 1 cycle after the last bit is accepted.
REQ-021 While byte_valid=1 and byte_ready=0, byte_out and byte_valid SHALL hold stable.
REQ-022 Each handshake SHALL advance to the next byte with no bubble, allowing one byte per cycle.
REQ-023 A handshake on byte K/8-1 SHALL drop byte_valid, pulse done for one cycle, and return to IDLE.
REQ-024 start outside IDLE SHALL be ignored, including the cycle of the final byte handshake.
REQ-025 bit_valid outside FILL SHALL be ignored.
REQ-026 A k_size_6144 change after start SHALL have no effect on the current block.
REQ-027 buf SHALL be a 6144x1 storage; for K=1056 only entries 0..1055 are used.

Reset
REQ-028 rst=0 SHALL, asynchronously, force state IDLE with byte_valid=0, byte_out=8'h00, busy=0, done=0, and clear i, pi, g, and the byte index.
REQ-029 rst asserted mid-FILL or mid-DRAIN SHALL abort the block; no partial bytes are emitted after release.
REQ-030 buf contents SHALL NOT be reset.

Verification
REQ-031 K=1056 single-one test: start; send bit_in=1 only at i=1 (pi=83), zeros elsewhere, byte_ready=1. Require 132 bytes, all 8'h00 except byte 10 = 8'h08, then a done pulse.
REQ-032 K=6144 single-one test: send bit_in=1 only at i=2 (pi=2446). Require 768 bytes, all 8'h00 except byte 305 = 8'h40, and busy low the cycle after done.
REQ-033 Round-trip test: take random 6144 bits c, send bit_in(i)=c[pi(i)] with random bit_valid gaps. Require output bytes to equal c packed LSB-first.
REQ-034 Backpressure test: hold byte_ready=0 for 5 cycles during byte 0 of DRAIN. Require byte_out and byte_valid stable throughout, and no byte skipped.
REQ-035 Reset test: pulse rst low at i=500 of FILL. Require immediate busy=0 and byte_valid=0; a subsequent full K=1056 block must then de-interleave correctly.
REQ-036 Ignored-input test: assert start during DRAIN and bit_valid during IDLE. Require no state change and byte count unchanged.
